// File: rtl/counter_pkg.sv
// Shared definitions for the BCD counter family: FSM states, digit limits
// and the digit sanitising helper.
package counter_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Largest legal BCD digit value.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Clamp a raw 4-bit code to a legal BCD digit.
  // Codes A..F become 9, so a bad preload or limit can never create a non-BCD count.
  function automatic logic [3:0] bcd_sat(input logic [3:0] v);
    logic [3:0] r;
    if (v > BCD_MAX) begin
      r = BCD_MAX;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Value one step above a two-digit BCD number, given as {tens, ones}.
  // The caller guarantees the input is not 99.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= BCD_MAX) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_up.sv
// Single BCD digit that counts 0..9 upward.
// 'wrap' flags that the digit sits at 9, so the next enabled step returns it to 0.
// Load has priority over counting, and the loaded digit is saturated to 9.
module bcd_digit_up
  import counter_pkg::*;
(
  input  logic       clock_in,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       wrap
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  // Next digit value: load, else step with 9->0 wrap, else hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = bcd_sat(d);
    end else if (en) begin
      if (q_q >= BCD_MAX) begin
        q_d = 4'd0;
      end else begin
        q_d = q_q + 4'd1;
      end
    end else begin
      q_d = q_q;
    end
  end

  // Digit register with synchronous reset to 0.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign wrap = (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_up_counter_2d.sv
// Two-digit BCD up-counter (00 -> limit).
// This module contains the run/done control FSM, the limit latch and the
// terminal compare. The count itself is stored in two cascaded digits.
// All status outputs are registered.
module bcd_up_counter_2d
  import counter_pkg::*;
#(
  parameter bit AUTO_CLEAR = 1'b0
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic [3:0] limit_tens,
  input  logic [3:0] limit_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry,
  output logic       busy,
  output logic       done
);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] lim_tens_q;
  logic [3:0] lim_tens_d;
  logic [3:0] lim_ones_q;
  logic [3:0] lim_ones_d;
  logic       carry_q;
  logic       carry_d;
  logic       busy_q;
  logic       busy_d;
  logic       done_q;
  logic       done_d;

  logic [3:0] tens_s;
  logic [3:0] ones_s;
  logic       ones_wrap_s;
  logic       tens_wrap_s;
  logic       cnt_en_s;
  logic       cnt_load_s;
  logic [3:0] ld_tens_s;
  logic [3:0] ld_ones_s;
  logic [3:0] in_lim_tens_s;
  logic [3:0] in_lim_ones_s;
  logic [7:0] nxt_cnt_s;
  logic       at_max_s;
  logic       reach_in_lim_s;
  logic       inc_hits_lim_s;
  logic       in_lim_zero_s;

  // The incoming limit is sanitised before it is latched or compared.
  assign in_lim_tens_s = bcd_sat(limit_tens);
  assign in_lim_ones_s = bcd_sat(limit_ones);
  assign in_lim_zero_s = ({in_lim_tens_s, in_lim_ones_s} == 8'h00);

  // Both operands are valid BCD, so a plain binary compare of {tens, ones} matches the numeric order.
  assign reach_in_lim_s = ({tens_s, ones_s} >= {in_lim_tens_s, in_lim_ones_s});

  // 99 is the absolute ceiling, so the counter never wraps to 00.
  assign at_max_s       = ones_wrap_s && tens_wrap_s;
  assign nxt_cnt_s      = bcd2_inc({tens_s, ones_s});
  assign inc_hits_lim_s = (nxt_cnt_s == {lim_tens_q, lim_ones_q});

  // Next state, limit latch, counter controls and the carry pulse.
  always_comb begin
    state_d    = state_q;
    lim_tens_d = lim_tens_q;
    lim_ones_d = lim_ones_q;
    cnt_en_s   = 1'b0;
    cnt_load_s = 1'b0;
    ld_tens_s  = 4'd0;
    ld_ones_s  = 4'd0;
    carry_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          cnt_load_s = 1'b1;
          ld_tens_s  = load_tens;
          ld_ones_s  = load_ones;
          state_d    = IDLE;
        end else if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          // A tick arriving together with start is deliberately not counted.
          lim_tens_d = in_lim_tens_s;
          lim_ones_d = in_lim_ones_s;
          if (reach_in_lim_s) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Load and start are ignored in RUN. Stop wins over a coincident tick.
        if (stop) begin
          state_d = IDLE;
        end else if (tick_in && !pause && !at_max_s) begin
          cnt_en_s = 1'b1;
          carry_d  = ones_wrap_s;
          if (inc_hits_lim_s) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (load) begin
          cnt_load_s = 1'b1;
          ld_tens_s  = load_tens;
          ld_ones_s  = load_ones;
          state_d    = IDLE;
        end else if (stop) begin
          state_d = IDLE;
        end else if (start && AUTO_CLEAR) begin
          // Clear to 00 and rerun. A zero limit is already reached, so the counter stays in DONE.
          cnt_load_s = 1'b1;
          ld_tens_s  = 4'd0;
          ld_ones_s  = 4'd0;
          lim_tens_d = in_lim_tens_s;
          lim_ones_d = in_lim_ones_s;
          if (in_lim_zero_s) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q    <= IDLE;
      lim_tens_q <= 4'd0;
      lim_ones_q <= 4'd0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lim_tens_q <= lim_tens_d;
      lim_ones_q <= lim_ones_d;
      carry_q    <= carry_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  bcd_digit_up u_ones (
    .clock_in (clock_in),
    .reset    (reset),
    .en       (cnt_en_s),
    .load     (cnt_load_s),
    .d        (ld_ones_s),
    .q        (ones_s),
    .wrap     (ones_wrap_s)
  );

  bcd_digit_up u_tens (
    .clock_in (clock_in),
    .reset    (reset),
    .en       (ones_wrap_s && cnt_en_s),
    .load     (cnt_load_s),
    .d        (ld_tens_s),
    .q        (tens_s),
    .wrap     (tens_wrap_s)
  );

  assign tens  = tens_s;
  assign ones  = ones_s;
  assign carry = carry_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bcd_up_counter_2d.sv
// Scoreboard bench for bcd_up_counter_2d.
// Two instances (AUTO_CLEAR = 0 and 1) share all inputs.
// Stimulus pushes the hand-computed expected outputs for the next cycle.
// A monitor pops and checks them on the falling edge.
module tb_bcd_up_counter_2d;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic [3:0] limit_tens = 4'd0;
  logic [3:0] limit_ones = 4'd0;
  logic [3:0] tens_a, ones_a, tens_b, ones_b;
  logic       carry_a, busy_a, done_a, carry_b, busy_b, done_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    string      nm;
    int         cyc;
    logic [10:0] ea;
    logic [10:0] eb;
  } exp_t;

  exp_t sb_q[$];

  bcd_up_counter_2d #(.AUTO_CLEAR(1'b0)) dut_a (
    .clock_in(clock_in), .reset(reset), .tick_in(tick_in), .start(start),
    .stop(stop), .pause(pause), .load(load), .load_tens(load_tens),
    .load_ones(load_ones), .limit_tens(limit_tens), .limit_ones(limit_ones),
    .tens(tens_a), .ones(ones_a), .carry(carry_a), .busy(busy_a), .done(done_a)
  );

  bcd_up_counter_2d #(.AUTO_CLEAR(1'b1)) dut_b (
    .clock_in(clock_in), .reset(reset), .tick_in(tick_in), .start(start),
    .stop(stop), .pause(pause), .load(load), .load_tens(load_tens),
    .load_ones(load_ones), .limit_tens(limit_tens), .limit_ones(limit_ones),
    .tens(tens_b), .ones(ones_b), .carry(carry_b), .busy(busy_b), .done(done_b)
  );

  always #5 clock_in = ~clock_in;

  always @(posedge clock_in) cyc <= cyc + 1;

  function automatic logic [10:0] pk(input logic [3:0] t, input logic [3:0] o,
                                     input logic c, input logic b, input logic d);
    return {t, o, c, b, d};
  endfunction

  task automatic chk(input string nm, input int ac, input logic [10:0] act, input logic [10:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s [AUTO_CLEAR=%0d] cycle %0d: got tens=%0d ones=%0d carry=%b busy=%b done=%b, want tens=%0d ones=%0d carry=%b busy=%b done=%b",
               nm, ac, cyc, act[10:7], act[6:3], act[2], act[1], act[0],
               ex[10:7], ex[6:3], ex[2], ex[1], ex[0]);
    end
  endtask

  // Monitor: check every expectation that is due on this cycle.
  always @(negedge clock_in) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d checked late at %0d", e.nm, e.cyc, cyc);
      end
      chk(e.nm, 0, {tens_a, ones_a, carry_a, busy_a, done_a}, e.ea);
      chk(e.nm, 1, {tens_b, ones_b, carry_b, busy_b, done_b}, e.eb);
    end
  end

  // Apply the inputs already set up by the caller for one clock.
  // Then release all strobes; pause is a level and is left as it is.
  task automatic stepab(input string nm, input logic [10:0] ea, input logic [10:0] eb);
    exp_t e;
    e.nm = nm;
    e.cyc = cyc + 1;
    e.ea = ea;
    e.eb = eb;
    sb_q.push_back(e);
    @(posedge clock_in);
    @(negedge clock_in);
    reset = 1'b0;
    tick_in = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    load = 1'b0;
  endtask

  task automatic step(input string nm, input logic [3:0] t, input logic [3:0] o,
                      input logic c, input logic b, input logic d);
    stepab(nm, pk(t, o, c, b, d), pk(t, o, c, b, d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    reset = 1'b1;
    step("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Count to 12. The tick that coincides with start is not counted.
    limit_tens = 4'd1; limit_ones = 4'd2; start = 1'b1; tick_in = 1'b1;
    step("start_lim12", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      tick_in = 1'b1;
      step("count_to_12", 4'(i / 10), 4'(i % 10), (i % 10 == 0), (i < 12), (i == 12));
    end
    repeat (2) begin
      tick_in = 1'b1;
      step("tick_in_done", 4'd1, 4'd2, 1'b0, 1'b0, 1'b1);
    end

    // Load 47 from DONE, then run to limit 50.
    load_tens = 4'd4; load_ones = 4'd7; load = 1'b1;
    step("load_47", 4'd4, 4'd7, 1'b0, 1'b0, 1'b0);
    limit_tens = 4'd5; limit_ones = 4'd0; start = 1'b1;
    step("start_lim50", 4'd4, 4'd7, 1'b0, 1'b1, 1'b0);
    tick_in = 1'b1; step("tick_48", 4'd4, 4'd8, 1'b0, 1'b1, 1'b0);
    tick_in = 1'b1; step("tick_49", 4'd4, 4'd9, 1'b0, 1'b1, 1'b0);
    tick_in = 1'b1; step("tick_50", 4'd5, 4'd0, 1'b1, 1'b0, 1'b1);

    // Pause drops ticks; stop with a coincident tick holds the count.
    stop = 1'b1;
    step("stop_done", 4'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    load_tens = 4'd0; load_ones = 4'd5; load = 1'b1;
    step("load_05", 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
    limit_tens = 4'd9; limit_ones = 4'd9; start = 1'b1;
    step("start_at_05", 4'd0, 4'd5, 1'b0, 1'b1, 1'b0);
    pause = 1'b1;
    repeat (5) begin
      tick_in = 1'b1;
      step("paused", 4'd0, 4'd5, 1'b0, 1'b1, 1'b0);
    end
    pause = 1'b0; tick_in = 1'b1;
    step("resume", 4'd0, 4'd6, 1'b0, 1'b1, 1'b0);
    stop = 1'b1; tick_in = 1'b1;
    step("stop_with_tick", 4'd0, 4'd6, 1'b0, 1'b0, 1'b0);

    // Full run to 99. The next tick must not wrap.
    load_tens = 4'd0; load_ones = 4'd0; load = 1'b1;
    step("load_00", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    limit_tens = 4'd9; limit_ones = 4'd9; start = 1'b1;
    step("start_lim99", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 99; i++) begin
      tick_in = 1'b1;
      step("count_to_99", 4'(i / 10), 4'(i % 10), (i % 10 == 0), (i < 99), (i == 99));
    end
    tick_in = 1'b1;
    step("no_wrap_99", 4'd9, 4'd9, 1'b0, 1'b0, 1'b1);

    // Sanitising, limit 00, and a start with the count already above the limit.
    stop = 1'b1;
    step("stop_99", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    load_tens = 4'hF; load_ones = 4'hC; load = 1'b1;
    step("load_sat_FC", 4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    load_tens = 4'd0; load_ones = 4'd0; load = 1'b1;
    step("load_00b", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    limit_tens = 4'd0; limit_ones = 4'd0; start = 1'b1;
    step("lim00_start", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    tick_in = 1'b1;
    step("lim00_tick", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    stop = 1'b1;
    step("stop_lim00", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    limit_tens = 4'd0; limit_ones = 4'hA; start = 1'b1;
    step("lim_0A_start", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick_in = 1'b1;
      step("count_to_09", 4'd0, 4'(i), 1'b0, (i < 9), (i == 9));
    end
    stop = 1'b1;
    step("stop_09", 4'd0, 4'd9, 1'b0, 1'b0, 1'b0);
    limit_tens = 4'd0; limit_ones = 4'd5; start = 1'b1;
    step("start_above_lim", 4'd0, 4'd9, 1'b0, 1'b0, 1'b1);

    // AUTO_CLEAR: start while DONE at 20.
    load_tens = 4'd1; load_ones = 4'd8; load = 1'b1;
    step("load_18", 4'd1, 4'd8, 1'b0, 1'b0, 1'b0);
    limit_tens = 4'd2; limit_ones = 4'd0; start = 1'b1;
    step("start_lim20", 4'd1, 4'd8, 1'b0, 1'b1, 1'b0);
    tick_in = 1'b1; step("tick_19", 4'd1, 4'd9, 1'b0, 1'b1, 1'b0);
    tick_in = 1'b1; step("tick_20", 4'd2, 4'd0, 1'b1, 1'b0, 1'b1);
    start = 1'b1;
    stepab("start_in_done", pk(4'd2, 4'd0, 1'b0, 1'b0, 1'b1), pk(4'd0, 4'd0, 1'b0, 1'b1, 1'b0));
    tick_in = 1'b1;
    stepab("tick_after_clear", pk(4'd2, 4'd0, 1'b0, 1'b0, 1'b1), pk(4'd0, 4'd1, 1'b0, 1'b1, 1'b0));

    // Reset while running at 33, with every other strobe asserted as well.
    reset = 1'b1;
    step("reset_realign", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    load_tens = 4'd3; load_ones = 4'd2; load = 1'b1;
    step("load_32", 4'd3, 4'd2, 1'b0, 1'b0, 1'b0);
    limit_tens = 4'd9; limit_ones = 4'd9; start = 1'b1;
    step("start_at_32", 4'd3, 4'd2, 1'b0, 1'b1, 1'b0);
    tick_in = 1'b1;
    step("tick_33", 4'd3, 4'd3, 1'b0, 1'b1, 1'b0);
    reset = 1'b1; tick_in = 1'b1; start = 1'b1; load = 1'b1; stop = 1'b1;
    step("reset_mid_run", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick_in = 1'b1;
    step("idle_after_reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    repeat (3) @(negedge clock_in);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations never checked, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_up_counter_2d.md
# bcd_up_counter_2d

Two-digit BCD up-counter (00→limit) for elapsed-time and event counting. It is the counting-up counterpart of the team's 9→0 BCD down-counter. It advances one step per qualified `tick_in` strobe and stops at a runtime limit. It is loadable, pausable and stoppable, and reports run and done status to the surrounding control FSM.

## Interface
Parameters:
- `AUTO_CLEAR`, default 0. Selects the behaviour of `start` while DONE:
  - 1: clear to 00 and re-run.
  - 0: ignore `start`.

Ports:
- `clock_in`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; one clock_in edge clears all state.
- `tick_in`  in  1  count-enable strobe, one cycle wide (e.g. 1 Hz prescaler).
- `start`  in  1  begin/resume counting.
- `stop`  in  1  abort the run; the count is held.
- `pause`  in  1  level; while high in RUN, ticks are ignored.
- `load`  in  1  preload the count from `load_tens`/`load_ones`.
- `load_tens`, `load_ones`  in  4 each  preload digits (BCD).
- `limit_tens`, `limit_ones`  in  4 each  terminal value (BCD). Sampled on the start edge.
- `tens`, `ones`  out  4 each  current count (BCD).
- `carry`  out  1  one-cycle pulse when `ones` wraps 9→0.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- States:
  - IDLE: reset state.
  - RUN: counting.
  - DONE: terminal.
- Reset values: `tens`=0, `ones`=0, `carry`=0, `busy`=0, `done`=0, state IDLE, latched limit 00.
- Input priority within a cycle: `reset` > `load` > `stop` > `start` > `tick_in`.
- IDLE:
  - `load`: count ← load digits; stay in IDLE.
  - `start`: latch the limit and go to RUN.
  - If the count is already ≥ the latched limit at start, go directly to DONE instead; the count is unchanged.
- RUN:
  - `tick_in` && !`pause`: increment. `ones`: 9→0 with `carry`=1 and `tens`+1; otherwise `ones`+1.
  - If the incremented value equals the limit, go to DONE on the same edge.
  - `stop`: go to IDLE, count held.
  - `load` and `start` are ignored in RUN.
- DONE:
  - Count frozen at the limit; ticks are ignored.
  - `load`: count ← load digits; go to IDLE.
  - `stop`: go to IDLE.
  - `start`: with `AUTO_CLEAR`=1, count ← 00, re-latch the limit, go to RUN; with `AUTO_CLEAR`=0, ignore.
- BCD sanitising: a load or limit digit >9 is saturated to 9. The count never holds a non-BCD code.
- Rollover: 99 is the absolute maximum. If the limit equals 99, DONE is reached at 99, so no 99→00 wrap ever occurs.
- Limit 00: `start` from count 00 goes to DONE on the next edge. `carry` stays low.

## Timing
- All outputs are registered. The count, `carry`, `busy` and `done` reflect an input on the cycle after the sampling edge.
- Tick-to-count latency is 1 cycle. `done` rises on the same edge that writes the limit value.
- `carry` is high for exactly one cycle per 9→0 wrap, including the wrap that lands on the limit, e.g. 09→10 at limit 10.
- `tick_in` coincident with `start` in IDLE: the tick is not counted. The first increment needs a tick after `busy` is high.
- `tick_in` coincident with `stop` in RUN: no increment.
- `pause` toggling mid-run loses no state. Ticks during pause are dropped, not queued.
- `reset` asserted mid-run returns all outputs to reset values on the next edge, regardless of other inputs.

## Structure
- Shared package `counter_pkg`:
  - state enum (IDLE, RUN, DONE)
  - `BCD_MAX` = 4'd9
  - BCD saturate function
- Sub-module `bcd_digit_up`: one digit with inputs `clock_in`, `reset`, `en`, `load`, `d[3:0]`, and outputs `q[3:0]`, `wrap`. Two instances are cascaded, with the tens `en` driven by ones `wrap` && `en`.
- The top level holds the FSM, the limit latch and the compare logic.

## Test plan
- Reset, then limit 12, `start`, 12 ticks: count 00→12, `carry` pulses once at 09→10, `done`=1 and `busy`=0 after the 12th tick; further ticks leave 12.
- Load 4,7 in IDLE, limit 5,0, `start`, 3 ticks: count 47→50, `done` asserted.
- In RUN at 05, assert `pause` for 5 ticks, then release and tick 1: count 05→06 with no change during pause; `stop` then returns to IDLE holding 06.
- Limit 9,9 from 00 with 99 ticks: `done` at 99, 9 `carry` pulses. The 100th tick keeps 99 with no wrap.
- Load digits F,C: count reads 99. Limit 00 and `start` from 00: DONE on the next edge.
- `AUTO_CLEAR`=1: in DONE at 20, `start` gives count 00 and `busy`=1. With `AUTO_CLEAR`=0, the same stimulus gives no change. `reset` mid-run at 33 gives 00, IDLE, all flags low.
